// File: rtl/data_bus_arbiter.sv
// Registered arbiter sharing the data-memory port between interrupt core, execute stage and debug port.
// Grant 1 cycle after request; BUSY until mem_cplt or timeout; one DONE cycle; requests are held off outside IDLE.
module data_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        int_req_i,
    input  logic        exe_req_i,
    input  logic        dbg_req_i,
    input  logic        int_rw_i,
    input  logic        exe_rw_i,
    input  logic        dbg_rw_i,
    input  logic [1:0]  int_size_i,
    input  logic [1:0]  exe_size_i,
    input  logic [1:0]  dbg_size_i,
    input  logic [31:0] int_addr_i,
    input  logic [31:0] exe_addr_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] int_wdata_i,
    input  logic [31:0] exe_wdata_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        int_lock_i,
    output logic        int_done_o,
    output logic        exe_done_o,
    output logic        dbg_done_o,
    output logic        int_err_o,
    output logic        exe_err_o,
    output logic        dbg_err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_rw_o,
    output logic [1:0]  mem_size_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_cplt_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_INT, OWN_EXE, OWN_DBG} owner_e;

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        grant;
    logic          rr_dbg_q, rr_dbg_d;
    logic          lock_q, lock_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    mem_rw_q, mem_rw_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [1:0]    mem_size_q, mem_size_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [2:0]    done_q, done_d;
    logic [2:0]    err_q, err_d;
    logic          busy_q, busy_d;
    logic [2:0]    owner_1h;

    assign owner_1h = {owner_q == OWN_DBG, owner_q == OWN_EXE, owner_q == OWN_INT};

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_dbg_d    = rr_dbg_q;
        lock_d      = lock_q;
        cnt_d       = cnt_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_size_d  = mem_size_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = '0;
        err_d       = '0;
        busy_d      = busy_q;
        grant       = OWN_NONE;

        unique case (state_q)
            S_IDLE: begin
                // A held lock blocks exe/dbg for this cycle even if it is released here.
                if (lock_q && !int_req_i)
                    lock_d = 1'b0;
                if (int_req_i)
                    grant = OWN_INT;
                else if (!lock_q) begin
                    if (exe_req_i && dbg_req_i)
                        grant = rr_dbg_q ? OWN_DBG : OWN_EXE;
                    else if (exe_req_i)
                        grant = OWN_EXE;
                    else if (dbg_req_i)
                        grant = OWN_DBG;
                end
                unique case (grant)
                    OWN_INT: begin
                        mem_rw_d    = {1'b1, int_rw_i};
                        mem_addr_d  = int_addr_i;
                        mem_size_d  = int_size_i;
                        mem_wdata_d = int_wdata_i;
                    end
                    OWN_EXE: begin
                        mem_rw_d    = {1'b1, exe_rw_i};
                        mem_addr_d  = exe_addr_i;
                        mem_size_d  = exe_size_i;
                        mem_wdata_d = exe_wdata_i;
                    end
                    OWN_DBG: begin
                        mem_rw_d    = {1'b1, dbg_rw_i};
                        mem_addr_d  = dbg_addr_i;
                        mem_size_d  = dbg_size_i;
                        mem_wdata_d = dbg_wdata_i;
                    end
                    default: mem_rw_d = 2'd0;
                endcase
                if (grant != OWN_NONE) begin
                    owner_d = grant;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes precedence over a timeout on the same edge.
                if (mem_cplt_i) begin
                    rdata_d  = mem_rw_q[0] ? 32'd0 : mem_rdata_i;
                    mem_rw_d = 2'd0;
                    done_d   = owner_1h;
                    state_d  = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d  = 32'd0;
                    mem_rw_d = 2'd0;
                    done_d   = owner_1h;
                    err_d    = owner_1h;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                lock_d = (owner_q == OWN_INT) && int_lock_i && !(|err_q);
                if (owner_q == OWN_EXE)
                    rr_dbg_d = 1'b1;
                else if (owner_q == OWN_DBG)
                    rr_dbg_d = 1'b0;
                owner_d = OWN_NONE;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            rr_dbg_q    <= 1'b0;
            lock_q      <= 1'b0;
            cnt_q       <= '0;
            mem_rw_q    <= 2'd0;
            mem_addr_q  <= 32'd0;
            mem_size_q  <= 2'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            done_q      <= 3'd0;
            err_q       <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_dbg_q    <= rr_dbg_d;
            lock_q      <= lock_d;
            cnt_q       <= cnt_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_size_q  <= mem_size_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign {dbg_done_o, exe_done_o, int_done_o} = done_q;
    assign {dbg_err_o, exe_err_o, int_err_o}    = err_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_rw_o    = mem_rw_q;
    assign mem_size_o  = mem_size_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule
